uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side buffer between the uart_rx deserializer and the CPU memory-mapped IO read path. It captures each byte that uart_rx flags with its one-cycle data-valid pulse into a circular FIFO, so the firmware polling loop cannot lose characters while busy. The CPU pops bytes through a registered read port timed for the processor's LOAD -> WAIT_DATA sequence. A status word reports occupancy and a sticky overrun flag.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
AW, 4, pointer width = log2(DEPTH).

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle pulse from uart_rx o_Rx_DV; byte present on rx_byte
rx_byte  in  8  received byte from uart_rx o_Rx_Byte
rd_strb  in  1  CPU read strobe (mem_rstrb qualified by IO page)
rd_sel  in  1  data-register word selected (one-hot IO address bit)
clr_ovr  in  1  one-cycle pulse; clears overrun flag (IO write to status word)
rd_data  out  32  registered pop result: bit8 = valid, bits7:0 = byte, others 0
status  out  32  {16'b0, count[AW:0] zero-extended to 13 bits, overrun, full, ~empty}
irq  out  1  registered, high while FIFO non-empty

Behaviour:
- Reset (resetn low, asynchronous, any time including mid-push or mid-pop): wr_ptr=0, rd_ptr=0, count=0, overrun=0, rd_data=0, irq=0. Storage contents are don't-care. Operation resumes on the first rising clk edge after resetn goes high.
- Storage: DEPTH x 8 array. Pointers are AW bits and wrap modulo DEPTH. count is AW+1 bits, range 0..DEPTH.
- empty = (count==0); full = (count==DEPTH). Both are combinational from count.
- push = rx_valid & (~full | pop). A push writes mem[wr_ptr] and increments wr_ptr.
- pop = rd_strb & rd_sel & ~empty. A pop increments rd_ptr.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Read latency is 1 cycle:
  - On a clk edge with rd_strb & rd_sel: rd_data <= {23'b0, ~empty, empty ? 8'h00 : mem[rd_ptr]}.
  - rd_data holds until the next rd_strb & rd_sel. It is therefore stable during WAIT_DATA.
  - rd_strb without rd_sel leaves rd_data and the pointers unchanged.
- Push and pop on the same edge:
  - When the FIFO is empty, the pop sees empty and returns valid=0. The pushed byte is stored. There is no bypass.
  - When the FIFO is full, the pop frees a slot and the push is accepted. count stays DEPTH and no overrun occurs.
- rx_valid while full with no pop: the byte is dropped and overrun <= 1 (sticky). Storage and pointers are unchanged.
- clr_ovr clears overrun. If clr_ovr coincides with a new overrun event, set wins (overrun=1).
- status is combinational from registered state: bit0 = ~empty, bit1 = full, bit2 = overrun, bits[3+AW:3] = count.
- irq <= ~empty after each edge's update, i.e. it reflects the next-state count.
- rx_valid is assumed to be a single-cycle pulse. Back-to-back pulses on consecutive cycles are each a separate push.

Test Plan:
- Reset state: after resetn 0->1 -> status=32'h0, rd_data=32'h0, irq=0; a read strobe gives rd_data=32'h0 (valid=0).
- Ordered transfer: push 8'h48, 8'h69, 8'h0A, then three rd_strb&rd_sel reads -> rd_data=32'h148, 32'h169, 32'h10A; count 3->0; a fourth read gives 32'h000.
- Fill and overrun: 17 pushes of 8'h00..8'h10 with DEPTH=16 -> status full=1, overrun=1, count=16; reads return 8'h00..8'h0F; 8'h10 is lost.
- Overrun clear priority: clr_ovr on the same edge as an overflow push -> overrun stays 1; clr_ovr alone later -> overrun=0.
- Simultaneous push/pop: full FIFO, push 8'hAA with pop -> count stays 16, no overrun, 8'hAA read last. Empty FIFO, push with pop -> rd_data valid=0, count=1.
- Wrap and reset: perform 40 push/pop pairs so pointers wrap twice, with data integrity checked. Then assert resetn low mid-sequence with count=5 -> status=0 immediately (asynchronously), before any clk edge.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART deserializer and the CPU IO read port.
// Bytes are pushed on rx_valid pulses; the CPU pops through a registered read port.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        rd_strb,
  input  logic        rd_sel,
  input  logic        clr_ovr,
  output logic [31:0] rd_data,
  output logic [31:0] status,
  output logic        irq
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam int          CNT_PAD  = 13 - (AW + 1);

  logic [DEPTH-1:0][7:0] mem_q;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  ovr_q, ovr_d;
  logic [31:0]           rd_data_q, rd_data_d;
  logic                  irq_q, irq_d;

  logic empty, full, rd_req, pop, push, ovr_evt;
  logic [7:0] rd_byte;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign rd_req  = rd_strb & rd_sel;
  assign pop     = rd_req & ~empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the byte.
  assign push    = rx_valid & (~full | pop);
  assign ovr_evt = rx_valid & full & ~pop;
  assign rd_byte = empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (rd_req) rd_data_d = {23'b0, ~empty, rd_byte};
    // Set beats clear when both land on the same edge.
    if (ovr_evt)      ovr_d = 1'b1;
    else if (clr_ovr) ovr_d = 1'b0;
    else              ovr_d = ovr_q;
    irq_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovr_q     <= 1'b0;
      rd_data_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovr_q     <= ovr_d;
      rd_data_q <= rd_data_d;
      irq_q     <= irq_d;
    end
  end

  // Storage needs no reset; contents are only observed behind count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_byte;
  end

  assign rd_data = rd_data_q;
  assign irq     = irq_q;
  assign status  = {16'b0, {CNT_PAD{1'b0}}, count_q, ovr_q, full, ~empty};

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: ordering, overrun, push/pop collisions, wrap, async reset.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rx_valid, rd_strb, rd_sel, clr_ovr;
  logic [7:0]  rx_byte;
  logic [31:0] rd_data, status;
  logic        irq;

  int n_chk  = 0;
  int n_pass = 0;

  uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rd_strb(rd_strb), .rd_sel(rd_sel), .clr_ovr(clr_ovr),
    .rd_data(rd_data), .status(status), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  // One clock: drive inputs away from the edge, release them #1 after it.
  task automatic cyc(input logic v, input logic [7:0] b, input logic s,
                     input logic sel, input logic c);
    @(negedge clk);
    rx_valid = v; rx_byte = b; rd_strb = s; rd_sel = sel; clr_ovr = c;
    @(posedge clk);
    #1;
    rx_valid = 1'b0; rd_strb = 1'b0; rd_sel = 1'b0; clr_ovr = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    cyc(1'b1, b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd();
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    resetn = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    rd_strb = 1'b0; rd_sel = 1'b0; clr_ovr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    chk("rst_status", status, 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rd();
    chk("rst_read", rd_data, 32'h0);

    // Ordered transfer
    push(8'h48); push(8'h69); push(8'h0A);
    chk("ord_status3", status, 32'h19);
    chk("ord_irq", {31'b0, irq}, 32'h1);
    rd(); chk("ord_rd0", rd_data, 32'h148);
    rd(); chk("ord_rd1", rd_data, 32'h169);
    rd(); chk("ord_rd2", rd_data, 32'h10A);
    chk("ord_status0", status, 32'h0);
    chk("ord_irq0", {31'b0, irq}, 32'h0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("strb_nosel_hold", rd_data, 32'h10A);
    rd(); chk("ord_rd_empty", rd_data, 32'h0);

    // Fill and overrun
    for (int i = 0; i < 17; i++) push(8'(i));
    chk("fill_status", status, 32'h87);
    chk("fill_irq", {31'b0, irq}, 32'h1);
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    chk("ovr_set_wins", status, 32'h87);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovr_clear", status, 32'h83);

    // Full: push with pop
    cyc(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0);
    chk("full_pp_rd", rd_data, 32'h100);
    chk("full_pp_status", status, 32'h83);
    for (int i = 1; i < 16; i++) begin
      rd(); chk($sformatf("drain_%0d", i), rd_data, 32'h100 | 32'(i));
    end
    rd(); chk("drain_AA", rd_data, 32'h1AA);
    chk("drain_status", status, 32'h0);

    // Empty: push with pop, no bypass
    cyc(1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
    chk("empty_pp_rd", rd_data, 32'h0);
    chk("empty_pp_status", status, 32'h09);
    rd(); chk("empty_pp_read", rd_data, 32'h133);

    // Wrap pointers several times
    for (int i = 0; i < 40; i++) begin
      b = 8'(i * 7 + 3);
      push(b);
      rd(); chk($sformatf("wrap_%0d", i), rd_data, {23'b0, 1'b1, b});
    end
    chk("wrap_status", status, 32'h0);

    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
    chk("pre_rst_status", status, 32'h29);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_status", status, 32'h0);
    chk("async_rst_irq", {31'b0, irq}, 32'h0);
    chk("async_rst_rd_data", rd_data, 32'h0);
    @(negedge clk) resetn = 1'b1;
    rd(); chk("post_rst_read", rd_data, 32'h0);
    chk("post_rst_status", status, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
